// File: rtl/axi_lite_pwm_slave.sv
// AXI4-Lite register slave (CTRL, PERIOD, DUTY, PRESCALE) driving a prescaled
// PWM generator whose period/duty shadows reload only at a period boundary.
//
// Handshake rule for every channel: a beat transfers on the rising edge where
// both valid and ready are high. The master holds address/data stable until
// that edge. This slave raises awready/wready (and arready) for exactly one
// cycle, and it holds bvalid/rvalid (and rdata) until the matching ready is seen.
`timescale 1ns/1ps
module axi_lite_pwm_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            pwm_out,
  output logic                            period_tick,
  output logic [1:0]                      dbg_wr_state_o,
  output logic [1:0]                      dbg_rd_state_o
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rd_state_e;

  logic [1:0]  rst_sync_q;
  logic        rst;
  wr_state_e   wr_state_q;
  rd_state_e   rd_state_q;
  logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] regs_q [4];
  logic [31:0] pcnt_q, pcnt_d, cnt_q, cnt_d;
  logic [31:0] period_sh_q, period_sh_d, duty_sh_q, duty_sh_d;
  logic        pwm_q, pwm_d, tick_q, tick_d;
  logic        en, inv;
  logic        unused_ok;

  // Reset asserts immediately and releases two clocks after the pin drops.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) rst_sync_q <= 2'b11;
    else                rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  // Write channel FSM: accept only when address and data are both valid.
  always_ff @(posedge s00_axi_aclk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) begin
          wr_state_q <= W_ACK;
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
        end
        W_ACK: begin
          wr_state_q <= W_RESP;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b1;
        end
        W_RESP: if (s00_axi_bready) begin
          wr_state_q <= W_IDLE;
          bvalid_q   <= 1'b0;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Register file: byte-enabled update on the address/data handshake edge.
  always_ff @(posedge s00_axi_aclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= 32'd0;
    end else if (wr_state_q == W_ACK) begin
      for (int b = 0; b < 4; b++) begin
        if (s00_axi_wstrb[b]) regs_q[s00_axi_awaddr[3:2]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read channel FSM: rdata is captured with the pre-write register value.
  always_ff @(posedge s00_axi_aclk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (s00_axi_arvalid) begin
          rd_state_q <= R_ACK;
          arready_q  <= 1'b1;
        end
        R_ACK: begin
          rd_state_q <= R_DATA;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b1;
          rdata_q    <= regs_q[s00_axi_araddr[3:2]];
        end
        R_DATA: if (s00_axi_rready) begin
          rd_state_q <= R_IDLE;
          rvalid_q   <= 1'b0;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign en  = regs_q[0][0];
  assign inv = regs_q[0][1];

  // PWM next state: prescaler, period counter and boundary shadow reload.
  // The >= compares keep a counter from running past a limit that was lowered.
  always_comb begin
    pcnt_d      = pcnt_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    tick_d      = 1'b0;
    pwm_d       = 1'b0;
    if (!en) begin
      pcnt_d      = 32'd0;
      cnt_d       = 32'd0;
      period_sh_d = regs_q[1];
      duty_sh_d   = regs_q[2];
    end else begin
      pwm_d = (cnt_q < duty_sh_q) ^ inv;
      if (pcnt_q >= regs_q[3]) begin
        pcnt_d = 32'd0;
        if (cnt_q >= period_sh_q) begin
          cnt_d       = 32'd0;
          period_sh_d = regs_q[1];
          duty_sh_d   = regs_q[2];
          tick_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end else begin
        pcnt_d = pcnt_q + 32'd1;
      end
    end
  end

  // PWM state registers.
  always_ff @(posedge s00_axi_aclk or posedge rst) begin
    if (rst) begin
      pcnt_q      <= 32'd0;
      cnt_q       <= 32'd0;
      period_sh_q <= 32'd0;
      duty_sh_q   <= 32'd0;
      pwm_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign pwm_out         = pwm_q;
  assign period_tick     = tick_q;
  assign dbg_wr_state_o  = wr_state_q;
  assign dbg_rd_state_o  = rd_state_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_pwm_slave.sv
// Bench for axi_lite_pwm_slave: AXI drivers, response scoreboard, PWM measurements.
`timescale 1ns/1ps
module tb_axi_lite_pwm_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        pwm_out, period_tick;
  logic [1:0]  dbg_wr_state, dbg_rd_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [4];
  logic [1:0]  b_exp_q [$];
  logic [33:0] r_exp_q [$];

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  axi_lite_pwm_slave dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .pwm_out(pwm_out), .period_tick(period_tick),
    .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference register file: byte lanes replaced where the strobe is set.
  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endfunction

  // High clocks per period: cnt runs 0..P, output high while cnt < D, each
  // cnt value lasts (S+1) clocks; INV flips the count.
  function automatic int exp_high(input int unsigned s, input int unsigned p, input int unsigned d, input bit inv_b);
    int unsigned per, on;
    per = p + 1;
    on  = (d < per) ? d : per;
    return int'((inv_b ? (per - on) : on) * (s + 1));
  endfunction

  // Write driver: aw_lead cycles of awvalid alone, b_hold cycles before bready.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int b_hold);
    int t;
    step();
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      step();
      check("aw_alone_no_accept", 64'({awready, wready}), 64'd0);
    end
    wvalid = 1'b1;
    b_exp_q.push_back(2'b00);
    t = 0;
    do begin step(); t++; end while (!awready && t < 20);
    if (!(awready && wready)) begin
      fail("write_accept");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin step(); t++; end
    if (!bvalid) begin fail("bvalid_rise"); return; end
    for (int i = 0; i < b_hold; i++) begin
      check("bvalid_held", 64'(bvalid), 64'd1);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    model_write(addr, data, strb);
  endtask

  // Read driver: expected data taken from the model at issue time.
  task automatic axi_read(input logic [3:0] addr, input int r_hold);
    int t;
    logic [33:0] exp;
    step();
    araddr = addr; arvalid = 1'b1;
    exp = {2'b00, model[addr[3:2]]};
    r_exp_q.push_back(exp);
    t = 0;
    do begin step(); t++; end while (!arready && t < 20);
    if (!arready) begin fail("read_accept"); arvalid = 1'b0; return; end
    step();
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin step(); t++; end
    if (!rvalid) begin fail("rvalid_rise"); return; end
    for (int i = 0; i < r_hold; i++) begin
      check("rdata_stable", 64'({rvalid, rdata}), 64'({1'b1, exp[31:0]}));
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic wait_tick();
    int t = 0;
    while (!period_tick && t < 1000) begin step(); t++; end
    if (!period_tick) fail("period_tick_wait");
  endtask

  // Count clocks and high clocks from one period_tick to the next.
  task automatic count_period(output int hi, output int gap);
    hi = 0; gap = 0;
    do begin
      if (pwm_out) hi++;
      step();
      gap++;
    end while (!period_tick && gap < 2000);
  endtask

  task automatic set_pwm(input int unsigned s, input int unsigned p, input int unsigned d, input logic [31:0] ctrl);
    axi_write(4'h0, 32'd0, 4'hF, 0, 0);
    axi_write(4'hC, 32'(s), 4'hF, 0, 0);
    axi_write(4'h4, 32'(p), 4'hF, 0, 0);
    axi_write(4'h8, 32'(d), 4'hF, 0, 0);
    axi_write(4'h0, ctrl, 4'hF, 0, 0);
  endtask

  task automatic pwm_measure(input string name, input int unsigned s, input int unsigned p,
                             input int unsigned d, input bit inv_b);
    int hi, gap;
    wait_tick();
    count_period(hi, gap);
    count_period(hi, gap);
    check({name, "_high"}, 64'(hi), 64'(exp_high(s, p, d, inv_b)));
    check({name, "_period"}, 64'(gap), 64'((p + 1) * (s + 1)));
  endtask

  // Scoreboard monitor: compares every completed response beat.
  initial begin
    forever begin
      @(negedge clk);
      if (bvalid && bready) begin
        if (b_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL bresp_unexpected: got 0x%0h, expected no response", bresp);
        end else check("bresp", 64'(bresp), 64'(b_exp_q.pop_front()));
      end
      if (rvalid && rready) begin
        if (r_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rdata_unexpected: got 0x%0h, expected no response", rdata);
        end else check("rresp_rdata", 64'({rresp, rdata}), 64'(r_exp_q.pop_front()));
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int hi_a, hi_b, gap, highs, t;
    int unsigned rs, rp, rd;
    bit rinv;
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;

    #100;
    check("reset_handshake", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
    check("reset_pwm", 64'({pwm_out, period_tick}), 64'd0);
    check("reset_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
    #100;
    areset = 1'b0;
    repeat (3) step();

    // Basic writes and readback.
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Partial strobe; low address bits ignored.
    axi_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(4'h4, 32'h11223344, 4'b0101, 0, 0);
    axi_read(4'h4, 0);
    axi_read(4'h7, 0);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else
        axi_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    // Simultaneous write and read of one register: read sees the old value.
    fork
      axi_write(4'h8, 32'hCAFE0123, 4'hF, 0, 0);
      axi_read(4'h8, 0);
    join
    axi_read(4'h8, 0);

    // Handshake stress: awvalid leads, rready held low.
    axi_write(4'hC, 32'h5A5A0F0F, 4'hF, 5, 0);
    axi_read(4'hC, 6);

    // bready low for 10 cycles while a second write is already offered.
    step();
    awaddr = 4'h4; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    b_exp_q.push_back(2'b00);
    t = 0;
    do begin step(); t++; end while (!awready && t < 20);
    if (!awready) fail("stress_first_accept");
    step();
    wdata = 32'h0A0B0C0D;
    b_exp_q.push_back(2'b00);
    for (int i = 0; i < 10; i++) begin
      check("stress_bvalid_held", 64'(bvalid), 64'd1);
      check("stress_no_second_accept", 64'({awready, wready}), 64'd0);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    model_write(4'h4, 32'h01020304, 4'hF);
    t = 0;
    while (!awready && t < 20) begin step(); t++; end
    if (!awready) fail("stress_second_accept");
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin step(); t++; end
    bready = 1'b1;
    step();
    bready = 1'b0;
    model_write(4'h4, 32'h0A0B0C0D, 4'hF);
    axi_read(4'h4, 0);

    // PWM waveform, inverted, and random configurations.
    set_pwm(0, 9, 3, 32'h1);
    pwm_measure("pwm_p9_d3", 0, 9, 3, 1'b0);

    // Glitch-free duty change in the middle of a period.
    wait_tick();
    fork
      count_period(hi_a, gap);
      axi_write(4'h8, 32'd8, 4'hF, 0, 0);
    join
    count_period(hi_b, gap);
    check("glitch_current_period_high", 64'(hi_a), 64'(exp_high(0, 9, 3, 1'b0)));
    check("glitch_next_period_high", 64'(hi_b), 64'(exp_high(0, 9, 8, 1'b0)));

    axi_write(4'h8, 32'd0, 4'hF, 0, 0);
    pwm_measure("pwm_duty0", 0, 9, 0, 1'b0);
    axi_write(4'h8, 32'd20, 4'hF, 0, 0);
    pwm_measure("pwm_duty20", 0, 9, 20, 1'b0);

    set_pwm(0, 9, 3, 32'h3);
    pwm_measure("pwm_inverted", 0, 9, 3, 1'b1);

    for (int i = 0; i < 3; i++) begin
      rs = $urandom_range(0, 3); rp = $urandom_range(0, 7); rd = $urandom_range(0, 10);
      rinv = 1'($urandom_range(0, 1));
      set_pwm(rs, rp, rd, {30'd0, rinv, 1'b1});
      pwm_measure("pwm_random", rs, rp, rd, rinv);
    end

    // EN low with INV set: output and tick stay low.
    set_pwm(0, 9, 3, 32'h2);
    highs = 0;
    for (int i = 0; i < 25; i++) begin
      if (pwm_out || period_tick) highs++;
      step();
    end
    check("disabled_outputs_low", 64'(highs), 64'd0);

    // Reset during W_RESP with the output held high.
    set_pwm(0, 9, 20, 32'h1);
    wait_tick();
    count_period(hi_a, gap);
    check("pre_reset_pwm_high", 64'(pwm_out), 64'd1);
    step();
    awaddr = 4'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    do begin step(); t++; end while (!awready && t < 20);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_reset_bvalid", 64'(bvalid), 64'd1);
    #2;
    areset = 1'b1;
    #1;
    check("async_reset_bvalid", 64'(bvalid), 64'd0);
    check("async_reset_pwm", 64'(pwm_out), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    areset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    repeat (4) step();
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    repeat (5) step();
    check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
